// File: rtl/div_arb_pkg.sv
// rtl/div_arb_pkg.sv - shared FSM encodings and default widths for divider controllers
// Purpose: common state type and default sizing reused by divider controllers.
// Contents: arb_state_t (IDLE/LOAD/RUN/DONE, 2 bits), DEF_N_REQ, DEF_W, DEF_BURST.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_W     = 4;
  localparam int DEF_BURST = 4;

endpackage

// File: rtl/div_arbiter_counter.sv
// rtl/div_arbiter_counter.sv - W-bit modulo counter used as the shared divider
// Purpose: counts 0..term while enabled, wrapping to 0 after term.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset
//   clr  in   synchronous clear (abort)
//   load in   synchronous restart at 0 for a new grant
//   en   in   advance enable
//   term in   W  terminal count (divisor - 1)
//   cnt  out  W  current count
//   tc   out  1 when cnt equals term
module mod_n_counter
  import div_arb_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin scheduler sharing one divide-by-N tick counter
// Purpose: grants one requester at a time a burst of BURST divided ticks at that
//   requester's divisor, then pulses done; round-robin pointer rotates on completion.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   count enable
//   clr      in   synchronous abort, dominates all but rst
//   req      in   N_REQ     level requests, held until done
//   div_flat in   N_REQ*W   divisor of requester i at [i*W +: W]
//   gnt      out  N_REQ     registered one-hot grant
//   tick     out  divided tick, one cycle wide
//   done     out  N_REQ     one-cycle completion pulse
//   busy     out  high while not IDLE
//   cnt      out  W         current divider count
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W,
  parameter int BURST = DEF_BURST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] div_flat,
  output logic [N_REQ-1:0]   gnt,
  output logic               tick,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [W-1:0]       cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = $clog2(BURST) + 1;

  arb_state_t     state_q, state_d;
  logic [PW-1:0]  sel_q, sel_d, ptr_q, ptr_d, sel_inc, pick_idx;
  logic [BW-1:0]  bcnt_q, bcnt_d;
  logic [W-1:0]   div_q, div_d, div_sel;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic           pick_found, tc;
  int             scan;

  mod_n_counter #(.W(W)) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .load (state_q == LOAD),
    .en   ((state_q == RUN) && en),
    .term (div_q - W'(1)),
    .cnt  (cnt),
    .tc   (tc)
  );

  assign tick = (state_q == RUN) && en && tc;
  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

  assign sel_inc = (sel_q == PW'(N_REQ - 1)) ? '0 : sel_q + PW'(1);
  assign div_sel = div_flat[int'(sel_q)*W +: W];

  // Walk downward so the requester closest above ptr is the last (winning) hit.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan = (int'(ptr_q) + i) % N_REQ;
      if (req[scan]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(scan);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    div_d   = div_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          state_d         = LOAD;
        end
      end
      LOAD: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_inc;
        end else begin
          bcnt_d  = '0;
          // A zero divisor would never reach terminal count; run it as divide-by-1.
          div_d   = (div_sel == '0) ? W'(1) : div_sel;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_inc;
        end else if (tick) begin
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == BW'(BURST - 1)) begin
            state_d       = DONE;
            gnt_d         = '0;
            done_d[sel_q] = 1'b1;
          end
        end
      end
      DONE: begin
        ptr_d   = sel_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      gnt_d   = '0;
      done_d  = '0;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      div_q   <= W'(1);
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      div_q   <= div_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter
module tb_div_arbiter;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [3:0]  req;
  logic [15:0] div_flat;
  logic [3:0]  gnt, done;
  logic        tick, busy;
  logic [3:0]  cnt;

  int nvec = 0;
  int nerr = 0;

  div_arbiter #(.N_REQ(4), .W(4), .BURST(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .req      (req),
    .div_flat (div_flat),
    .gnt      (gnt),
    .tick     (tick),
    .done     (done),
    .busy     (busy),
    .cnt      (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; req = 4'b0; div_flat = 16'h0;
    cyc(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b0;
    cyc(1);

    // single requester, divide by 6, four ticks then done
    div_flat[3:0] = 4'd6; en = 1'b1; req = 4'b0001;
    cyc(1);
    chk("t2_gnt", gnt, 4'b0001);
    chk("t2_busy", busy, 1);
    for (int k = 0; k < 24; k++) begin
      cyc(1);
      chk("t2_cnt", cnt, k % 6);
      chk("t2_tick", tick, (k % 6) == 5);
      if (k == 12) chk("t2_gnt_hold", gnt, 4'b0001);
    end
    cyc(1);
    chk("t2_done", done, 4'b0001);
    chk("t2_gnt_off", gnt, 0);
    req = 4'b0;
    cyc(1);
    chk("t2_done_off", done, 0);
    chk("t2_busy_off", busy, 0);

    // async reset in the middle of RUN
    div_flat[7:4] = 4'd5; req = 4'b0010;
    cyc(1);
    chk("t1_gnt", gnt, 4'b0010);
    cyc(3);
    chk("t1_cnt", cnt, 2);
    rst = 1'b1;
    #1;
    chk("t1_gnt_rst", gnt, 0);
    chk("t1_busy_rst", busy, 0);
    chk("t1_cnt_rst", cnt, 0);
    chk("t1_done_rst", done, 0);
    chk("t1_tick_rst", tick, 0);
    req = 4'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("t1_idle", busy, 0);

    // two held requesters alternate
    div_flat[3:0] = 4'd3; div_flat[11:8] = 4'd3; req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      cyc(1);
      chk("t3_gnt", gnt, (g % 2 == 0) ? 4'b0001 : 4'b0100);
      cyc(12);
      chk("t3_last_tick", tick, 1);
      cyc(1);
      chk("t3_done", done, (g % 2 == 0) ? 4'b0001 : 4'b0100);
      chk("t3_gnt_off", gnt, 0);
      if (g == 3) req = 4'b0;
      cyc(1);
      chk("t3_idle", busy, 0);
    end

    // en toggling every cycle, divide by 2
    div_flat[15:12] = 4'd2; req = 4'b1000;
    cyc(1);
    chk("t4_gnt", gnt, 4'b1000);
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      en = (k % 2 == 0);
      #1;
      chk("t4_cnt", cnt, ((k + 1) / 2) % 2);
      chk("t4_tick", tick, (k % 4) == 2);
    end
    cyc(1);
    chk("t4_done", done, 4'b1000);
    req = 4'b0; en = 1'b1;
    cyc(1);
    chk("t4_idle", busy, 0);

    // divisor 0 and 1 both tick every enabled cycle
    div_flat[3:0] = 4'd0; req = 4'b0001;
    cyc(1);
    chk("t5a_gnt", gnt, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("t5a_tick", tick, 1);
    end
    cyc(1);
    chk("t5a_done", done, 4'b0001);
    req = 4'b0;
    cyc(1);
    div_flat[7:4] = 4'd1; req = 4'b0010;
    cyc(1);
    chk("t5b_gnt", gnt, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("t5b_tick", tick, 1);
    end
    cyc(1);
    chk("t5b_done", done, 4'b0010);
    req = 4'b0;
    cyc(1);

    // clr in second tick period; ptr is 2 so requester 0 wins again
    div_flat[3:0] = 4'd3; div_flat[7:4] = 4'd2; req = 4'b0011;
    cyc(1);
    chk("t6_gnt0", gnt, 4'b0001);
    cyc(5);
    chk("t6_cnt", cnt, 1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("t6_clr_gnt", gnt, 0);
    chk("t6_clr_busy", busy, 0);
    chk("t6_clr_cnt", cnt, 0);
    chk("t6_clr_done", done, 0);
    cyc(1);
    chk("t6_ptr_kept", gnt, 4'b0001);
    // requester 0 drops mid-RUN: abort, then requester 1 is served
    cyc(2);
    req = 4'b0010;
    cyc(1);
    chk("t6_abort_gnt", gnt, 0);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_done", done, 0);
    cyc(1);
    chk("t6_gnt1", gnt, 4'b0010);
    // clr coinciding with the final tick suppresses done
    cyc(8);
    clr = 1'b1;
    #1;
    chk("t6_final_tick", tick, 1);
    cyc(1);
    clr = 1'b0; req = 4'b0;
    chk("t6_nodone", done, 0);
    chk("t6_final_busy", busy, 0);
    chk("t6_final_gnt", gnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
